psum_add4: RTL and testbench
============================

PSUM_ADD4 -- requirements
Module: psum_add4

Interface
REQ-001 Parameter LANES, default 32, number of parallel output-channel lanes.
REQ-002 Parameter IN_W, default 20, signed partial-sum width per lane.
REQ-003 Parameter OUT_W, default 22, signed accumulated width per lane (IN_W+2).
REQ-004 Parameter MAX_COL, default 256, maximum feature-map columns per row.
REQ-005 Parameter PASSES, default 4, input-channel groups summed per output.
REQ-006 clk  input  1  clock; all logic on rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 i_start  input  1  one-cycle pulse; latches i_fm_col and begins a row.
REQ-009 i_fm_col  input  16  columns per row for this row.
REQ-010 i_psum_valid  input  1  one column of partial sums present.
REQ-011 i_psum_data  input  LANES*IN_W  signed partial sums; lane k at [IN_W*k +: IN_W].
REQ-012 o_add4_valid  output  1  one column of final sums present.
REQ-013 o_add4_data  output  LANES*OUT_W  signed final sums; lane k at [OUT_W*k +: OUT_W].
REQ-014 o_add4_end  output  1  one-cycle pulse: row complete.
REQ-015 o_busy  output  1  high from accepted start until end pulse.
REQ-016 o_err  output  1  one-cycle pulse: start rejected.

Function
REQ-017 States IDLE, ACC, DONE; IDLE->ACC on accepted start, ACC->DONE after last column of pass PASSES-1, DONE->IDLE next cycle.
REQ-018 Start accepted only in IDLE with 1 <= i_fm_col <= MAX_COL; otherwise o_err pulses the next cycle and state stays IDLE.
REQ-019 i_start outside IDLE ignored, no o_err.
REQ-020 i_psum_valid ignored in IDLE and DONE.
REQ-021 col counter 0..fm_col-1 advances per valid column; at fm_col-1 wraps to 0 and pass counter increments.
REQ-022 Pass 0: buf[col] <= sign-extend(lane) to OUT_W, per lane.
REQ-023 Passes 1..PASSES-2: buf[col] <= buf[col] + sign-extend(lane), per lane.
REQ-024 Pass PASSES-1: o_add4_data <= buf[col] + sign-extend(lane); o_add4_valid high exactly one cycle later (latency 1); buf not written.
REQ-025 Arithmetic two's complement, OUT_W wide; no saturation (PASSES*IN_W range fits OUT_W).
REQ-026 o_add4_data holds last value when o_add4_valid low.
REQ-027 o_add4_end high during DONE, i.e. one cycle after the final o_add4_valid.
REQ-028 o_busy high in ACC and DONE.
REQ-029 Back-to-back valid every cycle supported; gaps of any length allowed, no timeout.
REQ-030 fm_col=1: each valid is a new pass; 4 valids -> 1 output column.

Reset
REQ-031 rst_n low: state IDLE, counters 0, o_add4_valid/o_add4_end/o_busy/o_err 0, o_add4_data 0.
REQ-032 Reset mid-row aborts the row with no end pulse; buffer contents undefined, not cleared.
REQ-033 First start after reset behaves identically to first start after power-up.

Structure
REQ-034 Package acc_pkg holds LANES, IN_W, OUT_W, MAX_COL, PASSES defaults and the state enum, shared with acc_bias_relu.
REQ-035 Column buffer is one sub-module psum_line_buf: MAX_COL x LANES*OUT_W, one async read port, one sync write port.
REQ-036 Lane adders are generated per lane inside psum_add4; no further sub-modules.

Verification
REQ-037 fm_col=3, all lanes psum=+1 every pass -> 3 valid columns each lane 4, end pulse one cycle after third.
REQ-038 fm_col=2, lane0 psums -524288 in all 4 passes -> lane0 output -2097152, no wrap.
REQ-039 fm_col=0 start -> o_err pulse, o_busy stays 0; fm_col=257 start -> same.
REQ-040 fm_col=4, valid with random 0-5 cycle gaps, start pulsed mid-row -> sums match model, start ignored, no o_err.
REQ-041 Reset asserted during pass 2 of fm_col=8 row, then new row fm_col=1 with psums 1,2,3,4 -> single output 10, one end pulse.
REQ-042 fm_col=1, lanes k psum=k each pass -> lane k output 4k, valid then end on consecutive cycles.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared defaults and state encoding for the accumulation datapath
// (psum_add4 and acc_bias_relu).
package acc_pkg;

  localparam int DEF_LANES   = 32;   // parallel output-channel lanes
  localparam int DEF_IN_W    = 20;   // signed partial-sum width per lane
  localparam int DEF_OUT_W   = 22;   // signed accumulated width per lane
  localparam int DEF_MAX_COL = 256;  // max feature-map columns per row
  localparam int DEF_PASSES  = 4;    // input-channel groups summed per output
  localparam int FM_COL_W    = 16;   // width of the per-row column count

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } acc_state_t;

endpackage

// File: rtl/psum_line_buf.sv
// Column buffer holding running per-lane sums for one feature-map row.
// Combinational read, registered write; contents are never cleared.
module psum_line_buf
  import acc_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_COL,
  parameter int WIDTH = DEF_LANES * DEF_OUT_W,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: one column per cycle when enabled.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/psum_add4.sv
// Sums PASSES groups of per-lane partial sums for one feature-map row.
// Passes 0..PASSES-2 accumulate into the column buffer; the last pass adds
// the buffered sum to the incoming column and emits it with one cycle of
// latency.
//
// Handshake: i_psum_valid qualifies i_psum_data for exactly one cycle and
// there is no back-pressure; every valid cycle while in ACC consumes one
// column. o_add4_valid likewise qualifies o_add4_data for one cycle and
// must be taken by the consumer when it is high.
module psum_add4
  import acc_pkg::*;
#(
  parameter int LANES   = DEF_LANES,
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int MAX_COL = DEF_MAX_COL,
  parameter int PASSES  = DEF_PASSES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic [15:0]            i_fm_col,
  input  logic                   i_psum_valid,
  input  logic [LANES*IN_W-1:0]  i_psum_data,
  output logic                   o_add4_valid,
  output logic [LANES*OUT_W-1:0] o_add4_data,
  output logic                   o_add4_end,
  output logic                   o_busy,
  output logic                   o_err,
  output logic [1:0]             o_dbg_state
);

  localparam int AW = (MAX_COL > 1) ? $clog2(MAX_COL) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int BW = LANES * OUT_W;

  acc_state_t          state_q;
  logic [FM_COL_W-1:0] fm_col_q;
  logic [AW-1:0]       col_q;
  logic [PW-1:0]       pass_q;

  logic [BW-1:0]       rd_data;
  logic [BW-1:0]       sum_data;
  logic                col_fire;
  logic                last_col;
  logic                first_pass;
  logic                last_pass;
  logic                start_ok;

  assign start_ok   = i_start && (i_fm_col != '0) && (i_fm_col <= FM_COL_W'(MAX_COL));
  assign col_fire   = (state_q == ST_ACC) && i_psum_valid;
  assign last_col   = (FM_COL_W'(col_q) == (fm_col_q - FM_COL_W'(1)));
  assign first_pass = (pass_q == '0);
  assign last_pass  = (pass_q == PW'(PASSES - 1));

  // Per-lane adder: first pass starts from zero, later passes add the
  // buffered running sum for the current column.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [IN_W-1:0]  in_lane;
    logic [OUT_W-1:0] in_ext;
    logic [OUT_W-1:0] acc_prev;

    assign in_lane  = i_psum_data[IN_W*k +: IN_W];
    assign in_ext   = {{(OUT_W-IN_W){in_lane[IN_W-1]}}, in_lane};
    assign acc_prev = first_pass ? '0 : rd_data[OUT_W*k +: OUT_W];
    assign sum_data[OUT_W*k +: OUT_W] = acc_prev + in_ext;
  end

  // The last pass only reads the buffer, so its write is suppressed.
  psum_line_buf #(
    .DEPTH (MAX_COL),
    .WIDTH (BW),
    .AW    (AW)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (col_fire && !last_pass),
    .wr_addr (col_q),
    .wr_data (sum_data),
    .rd_addr (col_q),
    .rd_data (rd_data)
  );

  // Row sequencer with column/pass counters and registered outputs.
  // o_busy stays high through the end-pulse cycle so the row is covered
  // from the cycle after start up to and including o_add4_end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fm_col_q     <= '0;
      col_q        <= '0;
      pass_q       <= '0;
      o_add4_valid <= 1'b0;
      o_add4_data  <= '0;
      o_add4_end   <= 1'b0;
      o_busy       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_add4_valid <= 1'b0;
      o_add4_end   <= 1'b0;
      o_err        <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          col_q  <= '0;
          pass_q <= '0;
          o_busy <= start_ok;
          if (start_ok) begin
            fm_col_q <= i_fm_col;
            state_q  <= ST_ACC;
          end else if (i_start) begin
            o_err <= 1'b1;
          end
        end
        ST_ACC: begin
          if (i_psum_valid) begin
            if (last_pass) begin
              o_add4_valid <= 1'b1;
              o_add4_data  <= sum_data;
            end
            if (last_col) begin
              col_q <= '0;
              if (last_pass) begin
                pass_q  <= '0;
                state_q <= ST_DONE;
              end else begin
                pass_q <= pass_q + PW'(1);
              end
            end else begin
              col_q <= col_q + AW'(1);
            end
          end
        end
        ST_DONE: begin
          o_add4_end <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_psum_add4.sv
// Directed testbench for psum_add4 using immediate assertions.
module tb_psum_add4;
  import acc_pkg::*;

  localparam int LANES   = DEF_LANES;
  localparam int IN_W    = DEF_IN_W;
  localparam int OUT_W   = DEF_OUT_W;
  localparam int MAX_COL = DEF_MAX_COL;
  localparam int IW      = LANES * IN_W;
  localparam int OW      = LANES * OUT_W;

  // Clock / reset
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [15:0]   i_fm_col = '0;
  logic          i_psum_valid = 1'b0;
  logic [IW-1:0] i_psum_data = '0;
  logic          o_add4_valid;
  logic [OW-1:0] o_add4_data;
  logic          o_add4_end;
  logic          o_busy;
  logic          o_err;
  logic [1:0]    o_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [OW-1:0] exp_q[$];

  always #5 clk = ~clk;

  psum_add4 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_fm_col     (i_fm_col),
    .i_psum_valid (i_psum_valid),
    .i_psum_data  (i_psum_data),
    .o_add4_valid (o_add4_valid),
    .o_add4_data  (o_add4_data),
    .o_add4_end   (o_add4_end),
    .o_busy       (o_busy),
    .o_err        (o_err),
    .o_dbg_state  (o_dbg_state)
  );

  // Driver tasks: inputs change 1 time unit after the rising edge,
  // outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_row(input logic [15:0] n);
    i_start  = 1'b1;
    i_fm_col = n;
    tick();
    i_start  = 1'b0;
  endtask

  task automatic send_col(input logic [IW-1:0] d);
    i_psum_valid = 1'b1;
    i_psum_data  = d;
    tick();
    i_psum_valid = 1'b0;
  endtask

  function automatic logic [IW-1:0] fill_in(input int v);
    logic [IW-1:0] d;
    for (int k = 0; k < LANES; k++) d[IN_W*k +: IN_W] = IN_W'(v);
    return d;
  endfunction

  function automatic int vpat(input int p, input int c, input int k);
    return p*100 - c*37 + k*5 - 60;
  endfunction

  function automatic logic [IW-1:0] pat_in(input int p, input int c);
    logic [IW-1:0] d;
    for (int k = 0; k < LANES; k++) d[IN_W*k +: IN_W] = IN_W'(vpat(p, c, k));
    return d;
  endfunction

  function automatic logic [OUT_W-1:0] lane_out(input int k);
    return o_add4_data[OUT_W*k +: OUT_W];
  endfunction

  // Scoreboard checks
  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_lane(input string tag, input logic [OUT_W-1:0] obs, input int exp);
    n_tests++;
    assert (obs === OUT_W'(exp)) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, $signed(obs), exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int n_valid;
    int n_bad;
    int n_end;
    int gap;
    int s;
    logic [OW-1:0] e;

    // ---- Reset state ----
    rst_n = 1'b0;
    repeat (3) tick();
    chk_bit("rst_valid", o_add4_valid, 1'b0);
    chk_bit("rst_end", o_add4_end, 1'b0);
    chk_bit("rst_busy", o_busy, 1'b0);
    chk_bit("rst_err", o_err, 1'b0);
    chk_bit("rst_data_zero", (o_add4_data == '0), 1'b1);
    chk_bit("rst_state_idle", (o_dbg_state == ST_IDLE), 1'b1);
    rst_n = 1'b1;
    tick();

    // ---- Valid in IDLE is ignored ----
    send_col(fill_in(77));
    chk_bit("idle_valid_ignored", o_add4_valid, 1'b0);
    chk_bit("idle_busy", o_busy, 1'b0);

    // ---- fm_col=1, lane k psum=k each pass -> 4k ----
    start_row(16'd1);
    chk_bit("c1_busy", o_busy, 1'b1);
    chk_bit("c1_err", o_err, 1'b0);
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < LANES; k++) i_psum_data[IN_W*k +: IN_W] = IN_W'(k);
      i_psum_valid = 1'b1;
      tick();
      i_psum_valid = 1'b0;
      if (p < 3) chk_bit("c1_early_valid", o_add4_valid, 1'b0);
    end
    chk_bit("c1_valid", o_add4_valid, 1'b1);
    chk_bit("c1_end_not_yet", o_add4_end, 1'b0);
    chk_lane("c1_lane0", lane_out(0), 0);
    chk_lane("c1_lane1", lane_out(1), 4);
    chk_lane("c1_lane7", lane_out(7), 28);
    chk_lane("c1_lane31", lane_out(31), 124);
    tick();
    chk_bit("c1_end", o_add4_end, 1'b1);
    chk_bit("c1_valid_drop", o_add4_valid, 1'b0);
    chk_lane("c1_hold_lane1", lane_out(1), 4);
    tick();
    chk_bit("c1_end_one_cycle", o_add4_end, 1'b0);
    chk_bit("c1_busy_clear", o_busy, 1'b0);

    // ---- fm_col=3, all lanes +1 every pass -> 3 columns of 4 ----
    start_row(16'd3);
    n_valid = 0;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 3; c++) begin
        send_col(fill_in(1));
        if (o_add4_valid) n_valid++;
        if (p == 3) begin
          chk_lane("c3_lane0", lane_out(0), 4);
          chk_lane("c3_lane31", lane_out(31), 4);
          chk_bit("c3_no_end_yet", o_add4_end, 1'b0);
        end
      end
    end
    chk_int("c3_valid_count", n_valid, 3);
    tick();
    chk_bit("c3_end", o_add4_end, 1'b1);
    chk_bit("c3_valid_after", o_add4_valid, 1'b0);
    tick();

    // ---- fm_col=2, most-negative lane0 input, no wrap ----
    start_row(16'd2);
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 2; c++) begin
        i_psum_data = '0;
        i_psum_data[IN_W*0 +: IN_W] = IN_W'(-524288);
        i_psum_data[IN_W*1 +: IN_W] = IN_W'(524287);
        i_psum_valid = 1'b1;
        tick();
        i_psum_valid = 1'b0;
        if (p == 3) begin
          chk_bit("neg_valid", o_add4_valid, 1'b1);
          chk_lane("neg_lane0", lane_out(0), -2097152);
          chk_lane("pos_lane1", lane_out(1), 2097148);
          chk_lane("zero_lane2", lane_out(2), 0);
        end
      end
    end
    tick();
    chk_bit("neg_end", o_add4_end, 1'b1);
    tick();

    // ---- Rejected starts ----
    start_row(16'd0);
    chk_bit("col0_err", o_err, 1'b1);
    chk_bit("col0_busy", o_busy, 1'b0);
    tick();
    chk_bit("col0_err_pulse", o_err, 1'b0);
    start_row(16'(MAX_COL + 1));
    chk_bit("col257_err", o_err, 1'b1);
    chk_bit("col257_busy", o_busy, 1'b0);
    chk_bit("col257_state", (o_dbg_state == ST_IDLE), 1'b1);
    tick();
    chk_bit("col257_err_pulse", o_err, 1'b0);

    // ---- fm_col=MAX_COL accepted, lane value = column index ----
    start_row(16'(MAX_COL));
    chk_bit("max_err", o_err, 1'b0);
    chk_bit("max_busy", o_busy, 1'b1);
    n_valid = 0;
    n_bad   = 0;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < MAX_COL; c++) begin
        send_col(fill_in(c));
        if (o_add4_valid) begin
          n_valid++;
          if (lane_out(0) !== OUT_W'(4*c) || lane_out(31) !== OUT_W'(4*c)) n_bad++;
        end
      end
    end
    chk_int("max_valid_count", n_valid, MAX_COL);
    chk_int("max_bad_columns", n_bad, 0);
    tick();
    chk_bit("max_end", o_add4_end, 1'b1);
    tick();

    // ---- fm_col=4, random gaps, start pulsed mid-row ----
    for (int c = 0; c < 4; c++) begin
      e = '0;
      for (int k = 0; k < LANES; k++) begin
        s = 0;
        for (int p = 0; p < 4; p++) s += vpat(p, c, k);
        e[OUT_W*k +: OUT_W] = OUT_W'(s);
      end
      exp_q.push_back(e);
    end
    start_row(16'd4);
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 4; c++) begin
        gap = $urandom_range(0, 5);
        repeat (gap) begin
          tick();
          chk_bit("gap_no_valid", o_add4_valid, 1'b0);
        end
        if (p == 1 && c == 1) begin
          start_row(16'd2);
          chk_bit("mid_start_no_err", o_err, 1'b0);
          chk_bit("mid_start_busy", o_busy, 1'b1);
          chk_bit("mid_start_state", (o_dbg_state == ST_ACC), 1'b1);
        end
        send_col(pat_in(p, c));
        if (p == 3) begin
          chk_bit("gap_out_valid", o_add4_valid, 1'b1);
          e = exp_q.pop_front();
          chk_vec("gap_sum", o_add4_data, e);
        end
      end
    end
    chk_int("gap_queue_empty", exp_q.size(), 0);
    tick();
    chk_bit("gap_end", o_add4_end, 1'b1);
    tick();

    // ---- Reset during pass 2 of fm_col=8, then fm_col=1 row ----
    start_row(16'd8);
    for (int i = 0; i < 19; i++) send_col(fill_in(1));
    chk_bit("abort_busy_before", o_busy, 1'b1);
    rst_n = 1'b0;
    tick();
    chk_bit("abort_busy", o_busy, 1'b0);
    chk_bit("abort_end", o_add4_end, 1'b0);
    chk_bit("abort_data_zero", (o_add4_data == '0), 1'b1);
    rst_n = 1'b1;
    n_end = 0;
    repeat (3) begin
      tick();
      if (o_add4_end) n_end++;
    end
    chk_int("abort_no_end", n_end, 0);
    start_row(16'd1);
    chk_bit("after_rst_busy", o_busy, 1'b1);
    for (int v = 1; v <= 4; v++) send_col(fill_in(v));
    chk_bit("after_rst_valid", o_add4_valid, 1'b1);
    chk_lane("after_rst_lane0", lane_out(0), 10);
    chk_lane("after_rst_lane31", lane_out(31), 10);
    n_end = 0;
    repeat (4) begin
      tick();
      if (o_add4_end) n_end++;
    end
    chk_int("after_rst_one_end", n_end, 1);
    chk_bit("after_rst_idle", o_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
